// File: rtl/pop_pkg.sv
// Shared definitions for the POP sample path: accumulator FSM encoding and
// the default widths agreed with the timer block.
package pop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_ACCUM  = 2'd2
    } state_e;

    localparam int CNT_WIDTH_DEF  = 16;
    localparam int ACC_WIDTH_DEF  = 24;
    localparam int SHOT_WIDTH_DEF = 16;
    localparam int NUM_SHOTS_DEF  = 256;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; edge_o is a one-cycle pulse per input rising edge.
module pulse_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pop_sample_accumulator.sv
// Counts detector pulses inside each sample window and sums NUM_SHOTS window
// counts into a saturating total presented on a valid/ready result port.
module pop_sample_accumulator
    import pop_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int SHOT_WIDTH = SHOT_WIDTH_DEF,
    parameter int NUM_SHOTS  = NUM_SHOTS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_gate,
    input  logic                 detector,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] result_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 result_saturated,
    output logic                 overrun
);

    // Returns {clipped, value}.
    function automatic logic [CNT_WIDTH:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return {1'b1, v};
        return {1'b0, v + CNT_WIDTH'(1)};
    endfunction

    function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] c);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH+1)'(c);
        if (s[ACC_WIDTH]) return {1'b1, {ACC_WIDTH{1'b1}}};
        return s;
    endfunction

    logic pulse_edge;

    pulse_sync_edge u_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (detector),
        .edge_o  (pulse_edge)
    );

    // gate_q[1] is the gate aligned with pulse_edge; gate_q[2] is its previous value.
    logic [2:0]            gate_q;
    logic                  gate_d, gate_rise;
    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [SHOT_WIDTH-1:0] shots_q, shots_d;
    logic                  sat_q, sat_d;
    logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_sat_q, res_sat_d;
    logic                  overrun_q, overrun_d;

    logic [CNT_WIDTH:0]    cnt_inc_r;
    logic [ACC_WIDTH:0]    acc_add_r;
    logic [SHOT_WIDTH-1:0] shots_next;
    logic                  sat_next;

    assign gate_d    = gate_q[1];
    assign gate_rise = gate_q[1] & ~gate_q[2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        shots_d     = shots_q;
        sat_d       = sat_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_sat_d   = res_sat_q;
        overrun_d   = overrun_q;
        cnt_inc_r   = cnt_inc(cnt_q);
        acc_add_r   = acc_add(acc_q, cnt_q);
        shots_next  = shots_q + SHOT_WIDTH'(1);
        sat_next    = sat_q | acc_add_r[ACC_WIDTH];

        if (res_valid_q && result_ready) res_valid_d = 1'b0;

        if (clear) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            shots_d   = '0;
            sat_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (gate_rise) begin
                        state_d = ST_WINDOW;
                        cnt_d   = CNT_WIDTH'(pulse_edge);
                    end
                end
                ST_WINDOW: begin
                    if (!gate_d) begin
                        state_d = ST_ACCUM;
                    end else if (pulse_edge) begin
                        cnt_d = cnt_inc_r[CNT_WIDTH-1:0];
                        if (cnt_inc_r[CNT_WIDTH]) sat_d = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    state_d = gate_d ? ST_WINDOW : ST_IDLE;
                    cnt_d   = gate_d ? CNT_WIDTH'(pulse_edge) : '0;
                    if (shots_next == SHOT_WIDTH'(NUM_SHOTS)) begin
                        if (!res_valid_q || result_ready) begin
                            res_data_d  = acc_add_r[ACC_WIDTH-1:0];
                            res_sat_d   = sat_next;
                            res_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        acc_d   = '0;
                        shots_d = '0;
                        sat_d   = 1'b0;
                    end else begin
                        acc_d   = acc_add_r[ACC_WIDTH-1:0];
                        shots_d = shots_next;
                        sat_d   = sat_next;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            shots_q     <= '0;
            sat_q       <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            gate_q      <= {gate_q[1:0], sample_gate};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            shots_q     <= shots_d;
            sat_q       <= sat_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_sat_q   <= res_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign result_data      = res_data_q;
    assign result_valid     = res_valid_q;
    assign result_saturated = res_sat_q;
    assign overrun          = overrun_q;

endmodule
